// File: rtl/riskv_pkg.sv
// Shared RV32I decode constants: ALU op codes, branch condition codes,
// major opcodes and the ALU operand-A source selector.
package riskv_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [2:0] BR_EQ    = 3'b000;
   localparam logic [2:0] BR_NE    = 3'b001;
   localparam logic [2:0] BR_NEVER = 3'b010;
   localparam logic [2:0] BR_LT    = 3'b100;
   localparam logic [2:0] BR_GE    = 3'b101;
   localparam logic [2:0] BR_LTU   = 3'b110;
   localparam logic [2:0] BR_GEU   = 3'b111;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      SRC_A_RS1  = 2'd0,
      SRC_A_PC   = 2'd1,
      SRC_A_ZERO = 2'd2
   } alu_src_a_e;

   // Base ALU operation for a funct3 before the funct7 SUB/SRA override.
   function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J immediate of an RV32I
// instruction and flags opcodes that have no known format.
module imm_gen
   import riskv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:0]           instr,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  illegal_format
);

   // R-type carries no immediate, so it yields zero but is still a known format.
   always_comb begin
      imm            = '0;
      illegal_format = 1'b0;
      case (instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:
            imm = DATA_WIDTH'($signed(instr[31:20]));
         OPC_STORE:
            imm = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));
         OPC_BRANCH:
            imm = DATA_WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         OPC_LUI, OPC_AUIPC:
            imm = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
         OPC_JAL:
            imm = DATA_WIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         OPC_OP:
            imm = '0;
         default:
            illegal_format = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched instruction into control and
// operand fields held in a single valid/ready pipeline register.
module decode_stage
   import riskv_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [31:0]           instr_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic                  flush_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [3:0]            ALUCtrl_o,
   output logic [2:0]            branch_o,
   output logic [DATA_WIDTH-1:0] imm_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic [4:0]            rs1_o,
   output logic [4:0]            rs2_o,
   output logic [4:0]            rd_o,
   output logic [1:0]            aluSrcA_o,
   output logic                  aluSrcB_o,
   output logic                  regWrite_o,
   output logic                  memRead_o,
   output logic                  memWrite_o,
   output logic                  isBranch_o,
   output logic                  jump_o,
   output logic                  illegal_o
);

   localparam int SHAMT_HI_W = 12 - SHIFT_WIDTH;
   localparam logic [SHAMT_HI_W-1:0] SRAI_HI = SHAMT_HI_W'(1) << (SHAMT_HI_W - 2);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [SHAMT_HI_W-1:0] shamt_hi;
   logic                  is_srai;
   logic [DATA_WIDTH-1:0] d_imm;
   logic                  illegal_format;
   logic                  bad_field;
   logic                  d_illegal;
   logic [3:0]            d_alu;
   logic [2:0]            d_branch;
   alu_src_a_e            d_src_a;
   logic                  d_src_b;
   logic                  d_reg_write;
   logic                  d_mem_read;
   logic                  d_mem_write;
   logic                  d_is_branch;
   logic                  d_jump;
   logic                  accept;

   alu_src_a_e            src_a_q;

   assign opcode   = instr_i[6:0];
   assign funct3   = instr_i[14:12];
   assign funct7   = instr_i[31:25];
   assign shamt_hi = instr_i[31:20+SHIFT_WIDTH];
   assign is_srai  = (funct3 == 3'b101) && (shamt_hi == SRAI_HI);

   imm_gen #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_imm_gen (
      .instr          (instr_i),
      .imm            (d_imm),
      .illegal_format (illegal_format)
   );

   // Illegal instructions still travel down the pipe, but with every side effect stripped.
   always_comb begin
      d_alu       = ALU_ADD;
      d_branch    = BR_NEVER;
      d_src_a     = SRC_A_RS1;
      d_src_b     = 1'b0;
      d_reg_write = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_is_branch = 1'b0;
      d_jump      = 1'b0;
      bad_field   = 1'b0;
      case (opcode)
         OPC_OP: begin
            d_alu = alu_op_from_funct3(funct3);
            if (funct7 == FUNCT7_ALT && funct3 == 3'b000) d_alu = ALU_SUB;
            if (funct7 == FUNCT7_ALT && funct3 == 3'b101) d_alu = ALU_SRA;
            bad_field   = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
            d_reg_write = 1'b1;
         end
         OPC_OP_IMM: begin
            d_alu = is_srai ? ALU_SRA : alu_op_from_funct3(funct3);
            if (funct3 == 3'b001 || funct3 == 3'b101)
               bad_field = (shamt_hi != '0) && !is_srai;
            d_src_b     = 1'b1;
            d_reg_write = 1'b1;
         end
         OPC_LOAD: begin
            d_src_b     = 1'b1;
            d_reg_write = 1'b1;
            d_mem_read  = 1'b1;
         end
         OPC_STORE: begin
            d_src_b     = 1'b1;
            d_mem_write = 1'b1;
         end
         OPC_BRANCH: begin
            d_alu       = ALU_SUB;
            d_branch    = funct3;
            d_is_branch = 1'b1;
            bad_field   = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_LUI: begin
            d_src_a     = SRC_A_ZERO;
            d_src_b     = 1'b1;
            d_reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            d_src_a     = SRC_A_PC;
            d_src_b     = 1'b1;
            d_reg_write = 1'b1;
         end
         OPC_JAL: begin
            d_src_a     = SRC_A_PC;
            d_src_b     = 1'b1;
            d_jump      = 1'b1;
            d_reg_write = 1'b1;
         end
         OPC_JALR: begin
            d_src_b     = 1'b1;
            d_jump      = 1'b1;
            d_reg_write = 1'b1;
         end
         default: ;
      endcase
      d_illegal = bad_field || illegal_format;
      if (d_illegal) begin
         d_reg_write = 1'b0;
         d_mem_read  = 1'b0;
         d_mem_write = 1'b0;
         d_is_branch = 1'b0;
         d_jump      = 1'b0;
      end
      if (instr_i[11:7] == 5'd0) d_reg_write = 1'b0;
   end

   assign ready_o = !valid_o || ready_i;
   assign accept  = valid_i && ready_o;

   // Flush wins over a same-cycle accept; the killed instruction is simply lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o    <= 1'b0;
         ALUCtrl_o  <= ALU_ADD;
         branch_o   <= BR_NEVER;
         imm_o      <= '0;
         pc_o       <= '0;
         rs1_o      <= '0;
         rs2_o      <= '0;
         rd_o       <= '0;
         src_a_q    <= SRC_A_RS1;
         aluSrcB_o  <= 1'b0;
         regWrite_o <= 1'b0;
         memRead_o  <= 1'b0;
         memWrite_o <= 1'b0;
         isBranch_o <= 1'b0;
         jump_o     <= 1'b0;
         illegal_o  <= 1'b0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (accept) begin
         valid_o    <= 1'b1;
         ALUCtrl_o  <= d_alu;
         branch_o   <= d_branch;
         imm_o      <= d_imm;
         pc_o       <= pc_i;
         rs1_o      <= instr_i[19:15];
         rs2_o      <= instr_i[24:20];
         rd_o       <= instr_i[11:7];
         src_a_q    <= d_src_a;
         aluSrcB_o  <= d_src_b;
         regWrite_o <= d_reg_write;
         memRead_o  <= d_mem_read;
         memWrite_o <= d_mem_write;
         isBranch_o <= d_is_branch;
         jump_o     <= d_jump;
         illegal_o  <= d_illegal;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

   assign aluSrcA_o = src_a_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed RV32I cases plus random
// traffic compared against a mnemonic-level reference decoder.
module tb_decode_stage;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] instr_i;
   logic [31:0] pc_i;
   logic        flush_i;
   logic        ready_i;
   logic        valid_o;
   logic [3:0]  ALUCtrl_o;
   logic [2:0]  branch_o;
   logic [31:0] imm_o;
   logic [31:0] pc_o;
   logic [4:0]  rs1_o;
   logic [4:0]  rs2_o;
   logic [4:0]  rd_o;
   logic [1:0]  aluSrcA_o;
   logic        aluSrcB_o;
   logic        regWrite_o;
   logic        memRead_o;
   logic        memWrite_o;
   logic        isBranch_o;
   logic        jump_o;
   logic        illegal_o;

   int cmp_count = 0;
   int err_count = 0;

   typedef struct packed {
      logic [3:0]  alu;
      logic [2:0]  br;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [1:0]  src_a;
      logic        src_b;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        is_branch;
      logic        jump;
      logic        illegal;
   } bundle_t;

   logic    exp_valid;
   bundle_t exp_b;

   decode_stage #(
      .DATA_WIDTH  (32),
      .SHIFT_WIDTH (5)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .instr_i    (instr_i),
      .pc_i       (pc_i),
      .flush_i    (flush_i),
      .ready_i    (ready_i),
      .valid_o    (valid_o),
      .ALUCtrl_o  (ALUCtrl_o),
      .branch_o   (branch_o),
      .imm_o      (imm_o),
      .pc_o       (pc_o),
      .rs1_o      (rs1_o),
      .rs2_o      (rs2_o),
      .rd_o       (rd_o),
      .aluSrcA_o  (aluSrcA_o),
      .aluSrcB_o  (aluSrcB_o),
      .regWrite_o (regWrite_o),
      .memRead_o  (memRead_o),
      .memWrite_o (memWrite_o),
      .isBranch_o (isBranch_o),
      .jump_o     (jump_o),
      .illegal_o  (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      cmp_count++;
      if (observed !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic bundle_t reset_bundle();
      bundle_t b;
      b     = '0;
      b.br  = 3'b010;
      return b;
   endfunction

   // Reference decoder works on mnemonic classes and weighted immediate bits.
   function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
      bundle_t b;
      int      f3_op [8] = '{0, 8, 5, 6, 4, 7, 3, 2};
      int      op  = int'(ins & 32'h7f);
      int      f3  = int'((ins >> 12) & 7);
      int      f7  = int'((ins >> 25) & 32'h7f);
      int      i_imm = int'($signed(ins)) >>> 20;
      b       = '0;
      b.br    = 3'b010;
      b.pc    = pc;
      b.rs1   = 5'((ins >> 15) & 31);
      b.rs2   = 5'((ins >> 20) & 31);
      b.rd    = 5'((ins >> 7) & 31);
      case (op)
         'h33: begin
            b.alu = 4'(f3_op[f3]);
            if (f7 == 32 && f3 == 0) b.alu = 4'd1;
            if (f7 == 32 && f3 == 5) b.alu = 4'd9;
            b.illegal   = !(f7 == 0 || f7 == 32);
            b.reg_write = 1'b1;
         end
         'h13: begin
            b.alu = 4'(f3_op[f3]);
            if (f3 == 5 && f7 == 32) b.alu = 4'd9;
            if (f3 == 1 || f3 == 5) b.illegal = (f7 != 0) && !(f3 == 5 && f7 == 32);
            b.imm = 32'(i_imm); b.src_b = 1'b1; b.reg_write = 1'b1;
         end
         'h03: begin
            b.imm = 32'(i_imm); b.src_b = 1'b1; b.reg_write = 1'b1; b.mem_read = 1'b1;
         end
         'h23: begin
            b.imm   = 32'((int'($signed(ins)) >>> 25) * 32 + int'((ins >> 7) & 31));
            b.src_b = 1'b1; b.mem_write = 1'b1;
         end
         'h63: begin
            b.imm = 32'(int'((ins >> 31) & 1) * -4096 + int'((ins >> 7) & 1) * 2048
                      + int'((ins >> 25) & 63) * 32 + int'((ins >> 8) & 15) * 2);
            b.alu = 4'd1; b.br = 3'(f3); b.is_branch = 1'b1;
            b.illegal = (f3 == 2 || f3 == 3);
         end
         'h37: begin
            b.imm = ins & 32'hFFFFF000; b.src_a = 2'd2; b.src_b = 1'b1; b.reg_write = 1'b1;
         end
         'h17: begin
            b.imm = ins & 32'hFFFFF000; b.src_a = 2'd1; b.src_b = 1'b1; b.reg_write = 1'b1;
         end
         'h6f: begin
            b.imm = 32'(int'((ins >> 31) & 1) * -1048576 + int'((ins >> 12) & 255) * 4096
                      + int'((ins >> 20) & 1) * 2048 + int'((ins >> 21) & 1023) * 2);
            b.src_a = 2'd1; b.src_b = 1'b1; b.jump = 1'b1; b.reg_write = 1'b1;
         end
         'h67: begin
            b.imm = 32'(i_imm); b.src_b = 1'b1; b.jump = 1'b1; b.reg_write = 1'b1;
         end
         default: b.illegal = 1'b1;
      endcase
      if (b.illegal) begin
         b.reg_write = 1'b0; b.mem_read = 1'b0; b.mem_write = 1'b0;
         b.is_branch = 1'b0; b.jump = 1'b0;
      end
      if (b.rd == 5'd0) b.reg_write = 1'b0;
      return b;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
      logic [6:0]  f7s [3] = '{7'h00, 7'h20, 7'h01};
      logic [31:0] ins = $urandom;
      if ($urandom_range(9, 0) == 0) return ins;
      ins[6:0] = ops[$urandom_range(8, 0)];
      if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(3, 0) != 0)
         ins[31:25] = f7s[$urandom_range(2, 0)];
      return ins;
   endfunction

   task automatic checkFields(input bundle_t e);
      checkOutput("ALUCtrl_o", 32'(ALUCtrl_o), 32'(e.alu));
      checkOutput("branch_o", 32'(branch_o), 32'(e.br));
      checkOutput("imm_o", imm_o, e.imm);
      checkOutput("pc_o", pc_o, e.pc);
      checkOutput("rs1_o", 32'(rs1_o), 32'(e.rs1));
      checkOutput("rs2_o", 32'(rs2_o), 32'(e.rs2));
      checkOutput("rd_o", 32'(rd_o), 32'(e.rd));
      checkOutput("aluSrcA_o", 32'(aluSrcA_o), 32'(e.src_a));
      checkOutput("aluSrcB_o", 32'(aluSrcB_o), 32'(e.src_b));
      checkOutput("regWrite_o", 32'(regWrite_o), 32'(e.reg_write));
      checkOutput("memRead_o", 32'(memRead_o), 32'(e.mem_read));
      checkOutput("memWrite_o", 32'(memWrite_o), 32'(e.mem_write));
      checkOutput("isBranch_o", 32'(isBranch_o), 32'(e.is_branch));
      checkOutput("jump_o", 32'(jump_o), 32'(e.jump));
      checkOutput("illegal_o", 32'(illegal_o), 32'(e.illegal));
   endtask

   task automatic checkBundle();
      checkOutput("valid_o", 32'(valid_o), 32'(exp_valid));
      if (exp_valid) checkFields(exp_b);
   endtask

   // Called at a falling edge; drives one cycle, advances the model, checks next falling edge.
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                input logic fl, input logic rdy);
      valid_i = v; instr_i = ins; pc_i = pc; flush_i = fl; ready_i = rdy;
      #1;
      checkOutput("ready_o", 32'(ready_o), 32'(!exp_valid || rdy));
      @(posedge clk_i);
      if (fl) exp_valid = 1'b0;
      else if (v && (!exp_valid || rdy)) begin
         exp_valid = 1'b1;
         exp_b     = model_decode(ins, pc);
      end else if (rdy) exp_valid = 1'b0;
      @(negedge clk_i);
      checkBundle();
   endtask

   initial begin
      rst_ni = 1'b0; valid_i = 1'b0; instr_i = '0; pc_i = '0; flush_i = 1'b0; ready_i = 1'b0;
      exp_valid = 1'b0;
      exp_b     = reset_bundle();
      repeat (2) @(negedge clk_i);
      checkOutput("rst_valid_o", 32'(valid_o), 32'd0);
      checkOutput("rst_ready_o", 32'(ready_o), 32'd1);
      checkFields(reset_bundle());
      rst_ni = 1'b1;

      applyStimulus(1'b1, 32'h407302B3, 32'h0000_1000, 1'b0, 1'b1);
      checkOutput("sub_valid", 32'(valid_o), 32'd1);
      checkOutput("sub_alu", 32'(ALUCtrl_o), 32'h1);
      checkOutput("sub_rs1", 32'(rs1_o), 32'd6);
      checkOutput("sub_rs2", 32'(rs2_o), 32'd7);
      checkOutput("sub_rd", 32'(rd_o), 32'd5);
      checkOutput("sub_regwrite", 32'(regWrite_o), 32'd1);
      checkOutput("sub_srcb", 32'(aluSrcB_o), 32'd0);

      applyStimulus(1'b1, 32'hFFF00093, 32'h0000_1004, 1'b0, 1'b1);
      checkOutput("addi_imm", imm_o, 32'hFFFFFFFF);
      checkOutput("addi_alu", 32'(ALUCtrl_o), 32'h0);
      checkOutput("addi_srcb", 32'(aluSrcB_o), 32'd1);
      checkOutput("addi_branch", 32'(branch_o), 32'h2);

      applyStimulus(1'b1, 32'h00209463, 32'h0000_1008, 1'b0, 1'b1);
      checkOutput("bne_branch", 32'(branch_o), 32'h1);
      checkOutput("bne_isbranch", 32'(isBranch_o), 32'd1);
      checkOutput("bne_imm", imm_o, 32'h00000008);
      checkOutput("bne_regwrite", 32'(regWrite_o), 32'd0);

      // Stall three cycles with a new instruction waiting, then flush the held bundle.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h407302B3, 32'h0000_2000, 1'b0, 1'b0);
         checkOutput("stall_ready_o", 32'(ready_o), 32'd0);
         checkOutput("stall_imm_hold", imm_o, 32'h00000008);
      end
      applyStimulus(1'b1, 32'h407302B3, 32'h0000_2000, 1'b1, 1'b0);
      checkOutput("flush_valid", 32'(valid_o), 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("flush_no_replay", 32'(valid_o), 32'd0);

      applyStimulus(1'b1, 32'hFFFFFFFF, 32'h0000_3000, 1'b0, 1'b1);
      checkOutput("ill_illegal", 32'(illegal_o), 32'd1);
      checkOutput("ill_valid", 32'(valid_o), 32'd1);
      checkOutput("ill_regwrite", 32'(regWrite_o), 32'd0);
      checkOutput("ill_memwrite", 32'(memWrite_o), 32'd0);

      // Asynchronous reset in the middle of a stall.
      applyStimulus(1'b1, 32'h407302B3, 32'h0000_4000, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'hFFF00093, 32'h0000_4004, 1'b0, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(valid_o), 32'd0);
      checkOutput("async_rst_branch", 32'(branch_o), 32'h2);
      checkOutput("async_rst_regwrite", 32'(regWrite_o), 32'd0);
      exp_valid = 1'b0;
      exp_b     = reset_bundle();
      @(negedge clk_i);
      rst_ni = 1'b1;
      applyStimulus(1'b1, 32'hFFF00093, 32'h0000_5000, 1'b0, 1'b1);
      checkOutput("post_rst_accept", 32'(valid_o), 32'd1);

      for (int n = 0; n < 1500; n++) begin
         applyStimulus($urandom_range(9, 0) < 7, rand_instr(), $urandom,
                       $urandom_range(19, 0) == 0, $urandom_range(9, 0) < 7);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath and instruction width.
REQ-002 SHALL have parameter SHIFT_WIDTH, default 5, shift-amount width checked on immediate shifts.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i input 1 rising-edge clock, then rst_ni input 1 async active-low reset.
REQ-004 SHALL have valid_i input 1 (fetch holds an instruction) and ready_o output 1 (stage accepts this cycle).
REQ-005 SHALL have instr_i input 32 (RV32I instruction) and pc_i input DATA_WIDTH (its PC).
REQ-006 SHALL have flush_i input 1, killing the held instruction.
REQ-007 SHALL have ready_i input 1 (execute accepts) and valid_o output 1 (decoded bundle valid).
REQ-008 SHALL have ALUCtrl_o output 4 (ALU op) and branch_o output 3 (branch condition code).
REQ-009 SHALL have imm_o output DATA_WIDTH (sign-extended immediate) and pc_o output DATA_WIDTH.
REQ-010 SHALL have rs1_o, rs2_o and rd_o outputs 5 each (register indices).
REQ-011 SHALL have aluSrcA_o output 2 (0 rs1, 1 PC, 2 zero) and aluSrcB_o output 1 (0 rs2, 1 imm).
REQ-012 SHALL have regWrite_o, memRead_o, memWrite_o, isBranch_o, jump_o and illegal_o outputs 1 each.

Function
REQ-013 SHALL register all outputs in one pipeline register; bundle appears the cycle after the valid_i && ready_o handshake.
REQ-014 SHALL drive ready_o = !valid_o || ready_i, combinationally.
REQ-015 SHALL hold every output stable while valid_o && !ready_i.
REQ-016 SHALL clear valid_o when ready_i=1 and no new instruction is accepted.
REQ-017 SHALL clear valid_o next cycle on flush_i, which takes priority over a simultaneous accept; the flushed instruction is dropped, not replayed.
REQ-018 SHALL encode ALUCtrl_o as ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SRL 0111, SLL 1000, SRA 1001.
REQ-019 SHALL select SUB/SRA for R-type when funct7=0100000, and SRA for SRAI when funct7=0100000 and funct3=101.
REQ-020 SHALL use ADD for loads, stores, LUI (srcA zero), AUIPC, JAL and JALR (srcA PC for AUIPC/JAL).
REQ-021 SHALL copy funct3 to branch_o for B-type and set isBranch_o; every other instruction SHALL get branch_o=010 (never taken).
REQ-022 SHALL generate I/S/B/U/J immediates sign-extended to DATA_WIDTH, with bit 0 of B/J immediates 0.
REQ-023 SHALL flag illegal_o for unknown opcodes, branch funct3 010/011, R-type funct7 other than 0000000/0100000, and shift-immediates with a nonzero funct7[6:0] other than SRAI's.
REQ-024 SHALL, for an illegal instruction, still assert valid_o with regWrite_o, memRead_o, memWrite_o, isBranch_o and jump_o all forced to 0.
REQ-025 SHALL force regWrite_o=0 when rd=0.

Reset
REQ-026 SHALL, with rst_ni low, clear valid_o and illegal_o, set ALUCtrl_o=0000, branch_o=010, and set all other outputs to 0, asynchronously.
REQ-027 SHALL discard an in-flight bundle on reset mid-operation; first acceptance is possible in the first clk_i edge after rst_ni rises.

Structure
REQ-028 SHALL place ALU op codes, branch codes, opcode constants and the aluSrcA enum in shared package riskv_pkg, used by the ALU too.
REQ-029 SHALL place immediate generation in sub-module imm_gen (combinational, instr in, imm and illegal-format out).

Verification
REQ-030 SHALL check 0x407302B3 (sub x5,x6,x7) accepted -> next cycle valid_o=1, ALUCtrl_o=0001, rs1=6, rs2=7, rd=5, regWrite_o=1, aluSrcB_o=0.
REQ-031 SHALL check 0xFFF00093 (addi x1,x0,-1) -> imm_o=0xFFFFFFFF, ALUCtrl_o=0000, aluSrcB_o=1, branch_o=010.
REQ-032 SHALL check 0x00209463 (bne x1,x2,+8) -> branch_o=001, isBranch_o=1, imm_o=0x00000008, regWrite_o=0.
REQ-033 SHALL check ready_i=0 for 3 cycles with valid_o=1 -> ready_o=0, outputs unchanged; then flush_i=1 -> valid_o=0 next cycle and the held bundle is never consumed.
REQ-034 SHALL check 0xFFFFFFFF -> illegal_o=1, valid_o=1, regWrite_o=memWrite_o=0.
REQ-035 SHALL check rst_ni dropped mid-stall -> valid_o=0 immediately without a clock edge, then a normal accept in the first cycle after release.
